onehot_event_encoder: RTL and testbench

ONEHOT_EVENT_ENCODER -- requirements
Module: onehot_event_encoder

---
 rtl/onehot_event_encoder.sv | 142 ++++++++++++++
 tb/tb_onehot_event_encoder.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/onehot_event_encoder.sv
// onehot_event_encoder: registers the encoded index of a one-hot event from a
// 2x4 decoder stage behind a valid/ready handshake. It also keeps a saturating
// event count for each line.
// Optional feature macro ONEHOT_CHECK_EN: when defined, zero-hot and multi-hot
// inputs are flagged through out_err and counted in err_cnt. When the macro is
// undefined, the input is plain priority encoded and out_err/err_cnt read zero.
module onehot_event_encoder #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             y0,
    input  logic             y1,
    input  logic             y2,
    input  logic             y3,
    output logic             in_ready,
    input  logic             clear,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       out_code,
    output logic             out_err,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1,
    output logic [CNT_W-1:0] cnt2,
    output logic [CNT_W-1:0] cnt3,
    output logic [CNT_W-1:0] err_cnt
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [3:0]       lines;
    logic             accept;
    logic [1:0]       enc_code;
    logic             enc_err;
    logic             count_line;
    logic [CNT_W-1:0] cnt_q [4];

    assign lines     = {y3, y2, y1, y0};
    assign out_valid = (state == FULL);
    assign in_ready  = (state == EMPTY) || out_ready;
    assign accept    = in_valid && in_ready;

    // Priority encoder: the highest set line wins, and zero-hot encodes as 0
    always_comb begin
        enc_code = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (lines[i]) begin
                enc_code = 2'(i);
            end
        end
    end

`ifdef ONEHOT_CHECK_EN
    logic             is_onehot;
    logic [CNT_W-1:0] err_cnt_q;

    assign is_onehot  = (lines != 4'b0000) && ((lines & (lines - 4'd1)) == 4'b0000);
    assign enc_err    = !is_onehot;
    assign count_line = accept && is_onehot;
    assign err_cnt    = err_cnt_q;

    // Saturating count of accepted events that were not exactly one-hot
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= '0;
        end else if (clear) begin
            err_cnt_q <= '0;
        end else if (accept && !is_onehot && (err_cnt_q != '1)) begin
            err_cnt_q <= err_cnt_q + 1'b1;
        end
    end
`else
    assign enc_err    = 1'b0;
    assign count_line = accept;
    assign err_cnt    = '0;
`endif

    // Register the handshake state (EMPTY or FULL)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // Next state: an accepted event fills the slot, and out_ready alone drains it
    always_comb begin
        state_next = state;
        case (state)
            EMPTY: begin
                if (accept) begin
                    state_next = FULL;
                end
            end
            FULL: begin
                if (accept) begin
                    state_next = FULL;
                end else if (out_ready) begin
                    state_next = EMPTY;
                end
            end
            default: state_next = EMPTY;
        endcase
    end

    // Capture the result on every accept; clear does not touch it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_code <= 2'd0;
            out_err  <= 1'b0;
        end else if (accept) begin
            out_code <= enc_code;
            out_err  <= enc_err;
        end
    end

    for (genvar g = 0; g < 4; g++) begin : g_line_cnt
        // Per-line saturating counter; clear wins over a coinciding event
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_q[g] <= '0;
            end else if (clear) begin
                cnt_q[g] <= '0;
            end else if (count_line && (enc_code == 2'(g)) && (cnt_q[g] != '1)) begin
                cnt_q[g] <= cnt_q[g] + 1'b1;
            end
        end
    end

    assign cnt0 = cnt_q[0];
    assign cnt1 = cnt_q[1];
    assign cnt2 = cnt_q[2];
    assign cnt3 = cnt_q[3];

endmodule

// File: tb/tb_onehot_event_encoder.sv
// tb_onehot_event_encoder: drives random and directed events into
// onehot_event_encoder and compares every output against a behavioural model
// built from integer counts.
module tb_onehot_event_encoder;

    localparam int CNT_W   = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             y0 = 1'b0, y1 = 1'b0, y2 = 1'b0, y3 = 1'b0;
    logic             in_ready;
    logic             clear = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [1:0]       out_code;
    logic             out_err;
    logic [CNT_W-1:0] cnt0, cnt1, cnt2, cnt3, err_cnt;

    int checks = 0;
    int errors = 0;

    // Model state
    bit m_valid;
    int m_code;
    bit m_err;
    int m_cnt [4];
    int m_err_cnt;
    bit last_in_ready;

    onehot_event_encoder #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .y0        (y0),
        .y1        (y1),
        .y2        (y2),
        .y3        (y3),
        .in_ready  (in_ready),
        .clear     (clear),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_code  (out_code),
        .out_err   (out_err),
        .cnt0      (cnt0),
        .cnt1      (cnt1),
        .cnt2      (cnt2),
        .cnt3      (cnt3),
        .err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic modelReset();
        m_valid   = 1'b0;
        m_code    = 0;
        m_err     = 1'b0;
        m_err_cnt = 0;
        for (int i = 0; i < 4; i++) m_cnt[i] = 0;
    endtask

    task automatic modelStep(input bit v, input bit [3:0] y, input bit clr, input bit ordy);
        bit acc;
        int ones;
        int hi;
        bit bad;
        acc  = v && (!m_valid || ordy);
        ones = $countones(y);
        hi   = 0;
        for (int i = 0; i < 4; i++) if (y[i]) hi = i;
`ifdef ONEHOT_CHECK_EN
        bad = (ones != 1);
`else
        bad = 1'b0;
`endif
        if (clr) begin
            for (int i = 0; i < 4; i++) m_cnt[i] = 0;
            m_err_cnt = 0;
        end else if (acc) begin
            if (bad) begin
                if (m_err_cnt < CNT_MAX) m_err_cnt++;
            end else begin
                if (m_cnt[hi] < CNT_MAX) m_cnt[hi]++;
            end
        end
        if (acc) begin
            m_valid = 1'b1;
            m_code  = hi;
            m_err   = bad;
        end else if (ordy) begin
            m_valid = 1'b0;
        end
    endtask

    // Compare every DUT output against the model
    task automatic checkOutput();
        check("out_valid", int'(out_valid), int'(m_valid));
        if (m_valid) begin
            check("out_code", int'(out_code), m_code);
            check("out_err", int'(out_err), int'(m_err));
        end
        check("cnt0", int'(cnt0), m_cnt[0]);
        check("cnt1", int'(cnt1), m_cnt[1]);
        check("cnt2", int'(cnt2), m_cnt[2]);
        check("cnt3", int'(cnt3), m_cnt[3]);
        check("err_cnt", int'(err_cnt), m_err_cnt);
    endtask

    // One cycle: drive inputs at the falling edge, let the rising edge act, then compare
    task automatic applyStimulus(input bit v, input bit [3:0] y, input bit clr, input bit ordy);
        in_valid  = v;
        {y3, y2, y1, y0} = y;
        clear     = clr;
        out_ready = ordy;
        #1;
        last_in_ready = in_ready;
        check("in_ready", int'(in_ready), int'(!m_valid || ordy));
        @(posedge clk);
        modelStep(v, y, clr, ordy);
        @(negedge clk);
        checkOutput();
    endtask

    task automatic checkAllZero(input string tag);
        check({tag, "_out_valid"}, int'(out_valid), 0);
        check({tag, "_out_code"}, int'(out_code), 0);
        check({tag, "_out_err"}, int'(out_err), 0);
        check({tag, "_cnt_sum"}, int'(cnt0) + int'(cnt1) + int'(cnt2) + int'(cnt3), 0);
        check({tag, "_err_cnt"}, int'(err_cnt), 0);
    endtask

    task automatic randomRun(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)),
                          $urandom_range(0, 31) == 0, $urandom_range(0, 1) == 1);
        end
    endtask

    initial begin
        modelReset();
        #12;
        checkAllZero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // A one-hot y2 event is accepted on the first edge after reset
        applyStimulus(1'b1, 4'b0100, 1'b0, 1'b1);
        check("pin29_valid", int'(out_valid), 1);
        check("pin29_code", int'(out_code), 2);
        check("pin29_err", int'(out_err), 0);
        check("pin29_cnt2", int'(cnt2), 1);
        check("pin29_cnt0", int'(cnt0), 0);
        applyStimulus(1'b0, 4'b0000, 1'b0, 1'b1);

        // Backpressure: the y1 result holds and the following y3 is blocked
        applyStimulus(1'b1, 4'b0010, 1'b0, 1'b0);
        applyStimulus(1'b1, 4'b1000, 1'b0, 1'b0);
        check("pin30_in_ready", int'(last_in_ready), 0);
        check("pin30_code", int'(out_code), 1);
        check("pin30_cnt3", int'(cnt3), 0);
        applyStimulus(1'b1, 4'b1000, 1'b0, 1'b1);
        check("pin30_code_after", int'(out_code), 3);
        check("pin30_cnt3_after", int'(cnt3), 1);
        applyStimulus(1'b0, 4'b0000, 1'b0, 1'b1);

        // Clear that coincides with an accept drops the count but keeps the result
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 4'b0001, 1'b0, 1'b1);
        check("pin33_cnt0_pre", int'(cnt0), 5);
        applyStimulus(1'b1, 4'b0001, 1'b1, 1'b1);
        check("pin33_cnt0", int'(cnt0), 0);
        check("pin33_valid", int'(out_valid), 1);
        check("pin33_code", int'(out_code), 0);

        // Multi-hot y1+y3
        applyStimulus(1'b0, 4'b0000, 1'b1, 1'b1);
        applyStimulus(1'b1, 4'b1010, 1'b0, 1'b1);
        check("pin32_code", int'(out_code), 3);
`ifdef ONEHOT_CHECK_EN
        check("pin32_err", int'(out_err), 1);
        check("pin32_err_cnt", int'(err_cnt), 1);
        check("pin32_cnt1", int'(cnt1), 0);
        check("pin32_cnt3", int'(cnt3), 0);
`else
        check("pin32_err", int'(out_err), 0);
        check("pin32_cnt3", int'(cnt3), 1);
`endif

        // Saturation: 300 y0 events leave cnt0 at 255
        applyStimulus(1'b0, 4'b0000, 1'b1, 1'b1);
        for (int i = 0; i < 300; i++) applyStimulus(1'b1, 4'b0001, 1'b0, 1'b1);
        check("pin31_cnt0", int'(cnt0), 255);

        randomRun(1500);

        // Asynchronous reset mid-transfer clears everything before the next edge
        applyStimulus(1'b1, 4'b0100, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        checkAllZero("async_reset");
        modelReset();
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b0, 4'b0000, 1'b0, 1'b1);
        check("no_replay_valid", int'(out_valid), 0);

        randomRun(1500);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
